// File: rtl/seq_frame_tx_if.sv
// Handshake/bus bundle for seq_frame_tx: frame request, payload and serial outputs.
// The master side requests frames; the slave side is the transmitter.
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data;
  logic              out;
  logic              busy;
  logic              done;

  modport master (output start, output data, input out, input busy, input done);
  modport slave  (input start, input data, output out, output busy, output done);
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble, MSB-first data word, optional even parity,
// then a run of idle zeros. All outputs are registered.
module seq_frame_tx #(
  parameter int             DATA_W     = 8,
  parameter int             PRE_W      = 4,
  parameter logic [PRE_W-1:0] PREAMBLE = 4'b0110,
  parameter bit             PARITY_EN  = 1'b1,
  parameter int             GAP_CYCLES = 2
) (
  input  logic           clock,
  input  logic           reset,
  seq_frame_tx_if.slave  bus
);

  localparam int MAX_A   = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int MAX_CNT = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               par_q, par_d;
  logic               out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PRE_W-1:0]   pre_sh_s;
  logic [DATA_W-1:0]  data_sh_s;

  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    out_d     = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    pre_sh_s  = {PRE_W{1'b0}};
    data_sh_s = {DATA_W{1'b0}};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = PRE;
          idx_d   = CNT_W'(PRE_W - 1);
          shreg_d = bus.data;
          par_d   = even_parity(bus.data);
        end else begin
          state_d = IDLE;
        end
      end
      PRE: begin
        if (idx_q == {CNT_W{1'b0}}) begin
          state_d = DATA;
          idx_d   = CNT_W'(DATA_W - 1);
        end else begin
          idx_d = idx_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (idx_q != {CNT_W{1'b0}}) begin
          idx_d = idx_q - CNT_W'(1);
        end else if (PARITY_EN) begin
          state_d = PAR;
        end else begin
          state_d = GAP;
          idx_d   = CNT_W'(GAP_CYCLES - 1);
        end
      end
      PAR: begin
        state_d = GAP;
        idx_d   = CNT_W'(GAP_CYCLES - 1);
      end
      GAP: begin
        if (idx_q == {CNT_W{1'b0}}) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = {CNT_W{1'b0}};
      end
    endcase

    // Shifting by the index selects the current bit without a width-mismatched bit-select.
    pre_sh_s  = PREAMBLE >> idx_d;
    data_sh_s = shreg_d >> idx_d;

    case (state_d)
      IDLE: begin
        out_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
      end
      PRE: begin
        out_d  = pre_sh_s[0];
        busy_d = 1'b1;
      end
      DATA: begin
        out_d  = data_sh_s[0];
        busy_d = 1'b1;
      end
      PAR: begin
        out_d  = par_d;
        busy_d = 1'b1;
      end
      GAP: begin
        out_d  = 1'b0;
        busy_d = 1'b1;
        done_d = (idx_d == {CNT_W{1'b0}});
      end
      default: begin
        out_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= {CNT_W{1'b0}};
      shreg_q <= {DATA_W{1'b0}};
      par_q   <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: frame-queue model compared every cycle,
// plus literal frame patterns for parity on/off, ignored start, mid-frame reset and loopback.
module tb_seq_frame_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data  = 8'h00;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  seq_frame_tx_if #(.DATA_W(8)) bus_p ();
  seq_frame_tx_if #(.DATA_W(8)) bus_n ();

  assign bus_p.start = start;
  assign bus_p.data  = data;
  assign bus_n.start = start;
  assign bus_n.data  = data;

  seq_frame_tx u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_p.slave)
  );

  seq_frame_tx #(.PARITY_EN(1'b0)) u_dut_np (
    .clock (clock),
    .reset (reset),
    .bus   (bus_n.slave)
  );

  // ---------------- behavioural model: list of per-cycle outputs per frame
  typedef struct packed {
    logic o;
    logic b;
    logic d;
  } exp_t;
  typedef exp_t eq_t[$];

  eq_t  q_p, q_n;
  exp_t e_p = '0;
  exp_t e_n = '0;

  function automatic eq_t build(input logic [7:0] d, input bit par_en);
    eq_t        q;
    logic [3:0] pre;
    pre = 4'b0110;
    for (int i = 3; i >= 0; i--) q.push_back('{o: pre[i], b: 1'b1, d: 1'b0});
    for (int i = 7; i >= 0; i--) q.push_back('{o: d[i], b: 1'b1, d: 1'b0});
    if (par_en) q.push_back('{o: ^d, b: 1'b1, d: 1'b0});
    for (int g = 0; g < 2; g++) q.push_back('{o: 1'b0, b: 1'b1, d: (g == 1)});
    q.push_back('{o: 1'b0, b: 1'b0, d: 1'b0});
    return q;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      q_p.delete();
      q_n.delete();
      e_p = '0;
      e_n = '0;
    end else begin
      if (q_p.size() == 0 && start) q_p = build(data, 1'b1);
      if (q_n.size() == 0 && start) q_n = build(data, 1'b0);
      if (q_p.size() > 0) e_p = q_p.pop_front(); else e_p = '0;
      if (q_n.size() > 0) e_n = q_n.pop_front(); else e_n = '0;
    end
  end

  always @(negedge clock) begin
    tests++;
    if ({bus_p.out, bus_p.busy, bus_p.done} !== e_p) begin
      fails++;
      $display("FAIL cycle_par: out/busy/done=%b required %b at %0t",
               {bus_p.out, bus_p.busy, bus_p.done}, e_p, $time);
    end
    tests++;
    if ({bus_n.out, bus_n.busy, bus_n.done} !== e_n) begin
      fails++;
      $display("FAIL cycle_nopar: out/busy/done=%b required %b at %0t",
               {bus_n.out, bus_n.busy, bus_n.done}, e_n, $time);
    end
  end

  // ---------------- frame capture for literal checks
  logic [14:0] cap_p = '0, last_p = '0;
  logic [13:0] cap_n = '0, last_n = '0;
  int len_p = 0, last_len_p = 0, dpos_p = 0, last_dpos_p = 0;
  int idle_p = 0, gap_p = 0, frames_p = 0;
  int len_n = 0, last_len_n = 0;
  logic [3:0] hist = 4'b0000;
  int det_cnt = 0;

  always @(negedge clock) begin
    hist = {hist[2:0], bus_p.out};
    if (hist == 4'b0110) det_cnt++;
    if (bus_p.busy) begin
      if (len_p == 0) begin
        gap_p = idle_p;
        frames_p++;
      end
      cap_p = {cap_p[13:0], bus_p.out};
      len_p++;
      if (bus_p.done) dpos_p = len_p;
      idle_p = 0;
    end else begin
      if (len_p != 0) begin
        last_p      = cap_p;
        last_len_p  = len_p;
        last_dpos_p = dpos_p;
      end
      len_p  = 0;
      cap_p  = '0;
      dpos_p = 0;
      idle_p++;
    end
    if (bus_n.busy) begin
      cap_n = {cap_n[12:0], bus_n.out};
      len_n++;
    end else begin
      if (len_n != 0) begin
        last_n     = cap_n;
        last_len_n = len_n;
      end
      len_n = 0;
      cap_n = '0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] d);
    data  = d;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  int f0, d0;

  initial begin
    // reset held two cycles with start high: no frame may begin
    reset = 1'b1;
    start = 1'b1;
    data  = 8'hA5;
    tick(2);
    reset = 1'b0;
    start = 1'b0;
    tick(2);
    @(posedge clock);
    check("reset_no_frame", 32'(frames_p), 32'd0);

    // basic frame 0xA5
    tick(1);
    send(8'hA5);
    tick(17);
    @(posedge clock);
    check("a5_bits", 32'(last_p), 32'(15'b011010100101000));
    check("a5_len", 32'(last_len_p), 32'd15);
    check("a5_done_pos", 32'(last_dpos_p), 32'd15);
    check("a5_np_bits", 32'(last_n), 32'(14'b01101010010100));
    check("a5_np_len", 32'(last_len_n), 32'd14);

    // parity: 0x01 -> 1, 0xFF -> 0
    tick(1);
    send(8'h01);
    tick(17);
    @(posedge clock);
    check("p01_bits", 32'(last_p), 32'(15'b011000000001100));
    check("p01_np_bits", 32'(last_n), 32'(14'b01100000000100));
    tick(1);
    send(8'hFF);
    tick(17);
    @(posedge clock);
    check("pff_bits", 32'(last_p), 32'(15'b011011111111000));

    // start during DATA of an A5 frame is ignored
    f0 = frames_p;
    tick(1);
    send(8'hA5);
    tick(6);
    send(8'h00);
    data = 8'hA5;
    tick(20);
    @(posedge clock);
    check("ignored_bits", 32'(last_p), 32'(15'b011010100101000));
    check("ignored_frames", 32'(frames_p - f0), 32'd1);

    // start held high: next frame exactly one idle cycle after busy falls
    tick(1);
    data  = 8'hA5;
    start = 1'b1;
    tick(35);
    start = 1'b0;
    @(posedge clock);
    check("b2b_gap", 32'(gap_p), 32'd1);
    tick(20);

    // reset at data bit 5 (sixth busy cycle counting from preamble start + 5)
    send(8'hA5);
    tick(9);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(posedge clock);
    check("midreset_busy", 32'(bus_p.busy), 32'd0);
    check("midreset_out", 32'(bus_p.out), 32'd0);
    tick(2);
    send(8'h3C);
    tick(17);
    @(posedge clock);
    check("after_reset_bits", 32'(last_p), 32'(15'b011000111100000));
    check("after_reset_len", 32'(last_len_p), 32'd15);

    // loopback: 0110 detector fires exactly once for a 0x00 frame
    tick(2);
    d0 = det_cnt;
    send(8'h00);
    tick(18);
    @(posedge clock);
    check("loopback_det", 32'(det_cnt - d0), 32'd1);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
